debounce_multi: RTL
===================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter DIV_WIDTH, default 21: prescaler counter width.
REQ-003 Parameter N_DIVIDE, default 21'd2000000: clocks per sample tick (100 MHz -> 50 Hz); 1 <= N_DIVIDE < 2^DIV_WIDTH.
REQ-004 Parameter STABLE_CNT, default 3: consecutive differing samples needed to accept a level change; >= 1.
REQ-005 Parameter LONG_CNT, default 100: sample ticks of held-high level that constitute a long press; >= 1.
REQ-006 clk  input  1  system clock; sole clock of the block.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in  input  N_CH  raw, asynchronous, bouncing inputs.
REQ-009 level  output  N_CH  debounced stable level per channel.
REQ-010 q_rise  output  N_CH  one-clk pulse per accepted 0->1 change.
REQ-011 q_fall  output  N_CH  one-clk pulse per accepted 1->0 change.
REQ-012 q_long  output  N_CH  one-clk pulse when level has been high for LONG_CNT ticks.
REQ-013 tick  output  1  one-clk sample-tick strobe, for use by neighbouring blocks.

Function
REQ-014 A shared prescaler shall count 0..N_DIVIDE-1 and wrap; tick shall be high combinationally while count == N_DIVIDE-1; N_DIVIDE = 1 shall give tick on every clk.
REQ-015 Each channel shall pass in through a two-flop synchronizer clocked every clk, independent of tick.
REQ-016 On tick, for each channel: synchronized value == level -> stability counter cleared; differs -> counter incremented.
REQ-017 When a tick finds a difference and the counter already equals STABLE_CNT-1, level shall toggle on that clk edge and the counter shall clear; STABLE_CNT = 1 accepts on the first differing tick.
REQ-018 Stability counter width shall be $clog2(STABLE_CNT+1); it shall never exceed STABLE_CNT-1.
REQ-019 q_rise/q_fall shall be registered, asserted for exactly one clk, on the clk after the edge where level toggled.
REQ-020 A differing run shorter than STABLE_CNT ticks shall produce no level change and no pulse.
REQ-021 Channels shall be fully independent; changes accepted on several channels on the same tick shall pulse all affected bits in the same clk.
REQ-022 Latency from a clean input step to the q_rise/q_fall pulse: 2 clk synchronizer + up to N_DIVIDE clk to the first tick + (STABLE_CNT-1)*N_DIVIDE clk + 1 clk.
REQ-023 Hold counter per channel: cleared while level = 0; incremented on tick while level = 1; saturates at LONG_CNT.
REQ-024 q_long shall pulse one clk, registered, on the clk after the hold counter reaches LONG_CNT; there is at most one pulse per high period and it re-arms only after level returns to 0.

Reset
REQ-025 While rst = 1 (sampled on clk): prescaler, synchronizers, stability and hold counters, level, q_rise, q_fall, q_long and tick shall all be 0.
REQ-026 Reset mid-count shall discard pending counts; an input held high through reset release shall yield level = 1 and a q_rise pulse after STABLE_CNT ticks.

Configuration
REQ-027 Macro DEBOUNCE_MULTI_LONGPRESS_EN defined: hold counters and q_long logic shall be built per REQ-023/024.
REQ-028 Macro undefined: q_long port shall remain present, tied to 0, with no hold-counter logic; all other behaviour unchanged.

Verification (N_CH=4, N_DIVIDE=10, STABLE_CNT=3, LONG_CNT=5)
REQ-029 in[0] 0->1 held -> level[0]=1 and one-clk q_rise[0] on the clk after the 3rd tick that samples the synchronized 1; no other bits pulse.
REQ-030 in[1] high for 2 ticks then low -> level[1] stays 0; q_rise[1] never asserts.
REQ-031 level[2], level[3] = 1, both inputs dropped on the same clk -> q_fall[3:2] = 2'b11 in a single clk.
REQ-032 rst pulsed after 2 differing ticks on ch0 -> all outputs 0 next clk; after release with in[0] still 1, q_rise[0] needs 3 fresh ticks.
REQ-033 With macro: ch0 held high 5 ticks after rise -> single q_long[0] pulse, none while held; after fall and re-rise, fires again. Without macro: q_long = 0 throughout.
REQ-034 Bounce at 1-clk intervals for 25 clk then settle high -> exactly one q_rise[0] and no q_fall[0].

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample prescaler, per-channel synchronizer, stability filter
// and edge pulses. Define DEBOUNCE_MULTI_LONGPRESS_EN to build the long-press detector.
module debounce_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIV_WIDTH  = 21,
  parameter int unsigned N_DIVIDE   = 2000000,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned LONG_CNT   = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] q_rise,
  output logic [N_CH-1:0] q_fall,
  output logic [N_CH-1:0] q_long,
  output logic            tick
);

  localparam int unsigned SW = $clog2(STABLE_CNT + 1);
  localparam logic [DIV_WIDTH-1:0] DivLast  = DIV_WIDTH'(N_DIVIDE - 1);
  localparam logic [SW-1:0]        StabLast = SW'(STABLE_CNT - 1);

  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick_int;
  logic [N_CH-1:0]      sync1_q, sync2_q;
  logic [N_CH-1:0]      level_q;
  logic [N_CH-1:0]      rise_q, fall_q;
  logic [SW-1:0]        stab_q [N_CH];
  logic [N_CH-1:0]      accept;

  assign tick_int = (div_q == DivLast);
  // Gated so the strobe reads 0 during reset even when N_DIVIDE = 1.
  assign tick     = tick_int & ~rst;

  always_comb begin
    accept = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      accept[ch] = tick_int && (sync2_q[ch] != level_q[ch]) && (stab_q[ch] == StabLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int ch = 0; ch < N_CH; ch++) stab_q[ch] <= '0;
    end else begin
      div_q   <= tick_int ? '0 : div_q + 1'b1;
      sync1_q <= in;
      sync2_q <= sync1_q;
      level_q <= level_q ^ accept;
      rise_q  <= accept & ~level_q;
      fall_q  <= accept & level_q;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (tick_int) begin
          if ((sync2_q[ch] == level_q[ch]) || accept[ch]) stab_q[ch] <= '0;
          else                                             stab_q[ch] <= stab_q[ch] + 1'b1;
        end
      end
    end
  end

  assign level  = level_q;
  assign q_rise = rise_q;
  assign q_fall = fall_q;

`ifdef DEBOUNCE_MULTI_LONGPRESS_EN
  localparam int unsigned HW = $clog2(LONG_CNT + 1);
  localparam logic [HW-1:0] HoldMax  = HW'(LONG_CNT);
  localparam logic [HW-1:0] HoldLast = HW'(LONG_CNT - 1);

  logic [HW-1:0]   hold_q [N_CH];
  logic [N_CH-1:0] long_q;

  // Hold counter saturates at LONG_CNT, so the LONG_CNT-1 crossing happens once per high period.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int ch = 0; ch < N_CH; ch++) hold_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        long_q[ch] <= tick_int && level_q[ch] && (hold_q[ch] == HoldLast);
        if (!level_q[ch])                          hold_q[ch] <= '0;
        else if (tick_int && hold_q[ch] != HoldMax) hold_q[ch] <= hold_q[ch] + 1'b1;
      end
    end
  end

  assign q_long = long_q;
`else
  assign q_long = '0;
`endif

endmodule
